// File: rtl/simd_alu_pkg.sv
// Shared SIMD ALU definitions: widths, opcodes and the result-entry payload.
package simd_alu_pkg;

  localparam int unsigned SIMD_DATA_WIDTH = 256;
  localparam int unsigned SIMD_OPC_WIDTH  = 4;
  localparam int unsigned SIMD_TAG_WIDTH  = 4;

  localparam logic [SIMD_OPC_WIDTH-1:0] SIMD_OPC_ADD = 4'h0;
  localparam logic [SIMD_OPC_WIDTH-1:0] SIMD_OPC_SUB = 4'h1;
  localparam logic [SIMD_OPC_WIDTH-1:0] SIMD_OPC_MUL = 4'h2;
  localparam logic [SIMD_OPC_WIDTH-1:0] SIMD_OPC_AND = 4'h3;
  localparam logic [SIMD_OPC_WIDTH-1:0] SIMD_OPC_OR  = 4'h4;
  localparam logic [SIMD_OPC_WIDTH-1:0] SIMD_OPC_XOR = 4'h5;
  localparam logic [SIMD_OPC_WIDTH-1:0] SIMD_OPC_SHL = 4'h6;
  localparam logic [SIMD_OPC_WIDTH-1:0] SIMD_OPC_SHR = 4'h7;

  typedef struct packed {
    logic [SIMD_DATA_WIDTH-1:0] data;
    logic [SIMD_TAG_WIDTH-1:0]  tag;
    logic                       ovf;
    logic                       unf;
  } simd_result_t;

endpackage

// File: rtl/simd_alu_lat_pipe.sv
// {valid, tag} delay line matching the ALU latency; reports how many stages hold an op.
module simd_alu_lat_pipe
  import simd_alu_pkg::*;
#(
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned TAG_WIDTH = 4,
  parameter int unsigned CNT_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [CNT_WIDTH-1:0] inflight_c
);

  logic [LATENCY-1:0]                valid_q, valid_d;
  logic [LATENCY-1:0][TAG_WIDTH-1:0] tag_q, tag_d;

  always_comb begin
    valid_d    = valid_q;
    tag_d      = tag_q;
    inflight_c = '0;
    valid_d[0] = in_valid;
    tag_d[0]   = in_tag;
    for (int i = 1; i < int'(LATENCY); i++) begin
      valid_d[i] = valid_q[i-1];
      tag_d[i]   = tag_q[i-1];
    end
    for (int i = 0; i < int'(LATENCY); i++) begin
      inflight_c = inflight_c + CNT_WIDTH'(valid_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_tag   = tag_q[LATENCY-1];

endmodule

// File: rtl/simd_alu_result_queue.sv
// SIMD ALU result stage: latency-matched capture into a credit-protected FIFO.
// Optional sticky overflow/underflow flags built when SIMD_ALU_RESULT_STICKY_EN is defined.
module simd_alu_result_queue
  import simd_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = SIMD_DATA_WIDTH,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ALU_LATENCY = 1,
  parameter int unsigned TAG_WIDTH   = SIMD_TAG_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [TAG_WIDTH-1:0]     issue_tag,
  output logic                     issue_ready,
  input  logic [DATA_WIDTH-1:0]    alu_out,
  input  logic                     alu_overflow,
  input  logic                     alu_underflow,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_WIDTH-1:0]    res_data,
  output logic [TAG_WIDTH-1:0]     res_tag,
  output logic                     res_overflow,
  output logic                     res_underflow,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     flags_clr,
  output logic                     sticky_ovf,
  output logic                     sticky_unf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned INF_W = $clog2(ALU_LATENCY + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  ovf;
    logic                  unf;
  } entry_t;

  logic                 cap_valid;
  logic [TAG_WIDTH-1:0] cap_tag;
  logic [INF_W-1:0]     inflight_c;
  logic                 issue_fire_c;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_c, push_c, pop_c;

  // Credit check uses registered state only, so issue_ready never depends on res_ready.
  assign issue_ready  = (32'(count_q) + 32'(inflight_c)) < 32'(DEPTH);
  assign issue_fire_c = issue_valid && issue_ready;

  simd_alu_lat_pipe #(
    .LATENCY   (ALU_LATENCY),
    .TAG_WIDTH (TAG_WIDTH),
    .CNT_WIDTH (INF_W)
  ) u_lat_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (issue_fire_c),
    .in_tag     (issue_tag),
    .out_valid  (cap_valid),
    .out_tag    (cap_tag),
    .inflight_c (inflight_c)
  );

  assign full_c = (count_q == CNT_W'(DEPTH));
  assign push_c = cap_valid && !full_c;
  assign pop_c  = (count_q != '0) && res_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = '{data: alu_out, tag: cap_tag, ovf: alu_overflow, unf: alu_underflow};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign res_valid     = (count_q != '0);
  assign res_data      = mem_q[rd_ptr_q].data;
  assign res_tag       = mem_q[rd_ptr_q].tag;
  assign res_overflow  = mem_q[rd_ptr_q].ovf;
  assign res_underflow = mem_q[rd_ptr_q].unf;
  assign count         = count_q;

`ifdef SIMD_ALU_RESULT_STICKY_EN
  logic sticky_ovf_q, sticky_ovf_d, sticky_unf_q, sticky_unf_d;

  // Clear wins over a capture in the same cycle.
  always_comb begin
    sticky_ovf_d = sticky_ovf_q | (push_c & alu_overflow);
    sticky_unf_d = sticky_unf_q | (push_c & alu_underflow);
    if (flags_clr) begin
      sticky_ovf_d = 1'b0;
      sticky_unf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_ovf_q <= 1'b0;
      sticky_unf_q <= 1'b0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
      sticky_unf_q <= sticky_unf_d;
    end
  end

  assign sticky_ovf = sticky_ovf_q;
  assign sticky_unf = sticky_unf_q;
`else
  logic unused_flags_clr;
  assign unused_flags_clr = flags_clr;
  assign sticky_ovf       = 1'b0;
  assign sticky_unf       = 1'b0;
`endif

  // A capture into a full FIFO means the issuer ignored issue_ready.
  assert property (@(posedge clk) disable iff (!rst_n) !(cap_valid && full_c));

endmodule

// File: tb/tb_simd_alu_result_queue.sv
// Scoreboard bench for simd_alu_result_queue (DEPTH=4, ALU_LATENCY=1).
module tb_simd_alu_result_queue;

`ifdef SIMD_ALU_RESULT_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         issue_valid;
  logic [3:0]   issue_tag;
  logic         issue_ready;
  logic [255:0] alu_out;
  logic         alu_overflow, alu_underflow;
  logic         res_valid, res_ready;
  logic [255:0] res_data;
  logic [3:0]   res_tag;
  logic         res_overflow, res_underflow;
  logic [2:0]   count;
  logic         flags_clr, sticky_ovf, sticky_unf;

  always #5 clk = ~clk;

  simd_alu_result_queue #(.DATA_WIDTH(256), .DEPTH(4), .ALU_LATENCY(1), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_tag(issue_tag),
    .issue_ready(issue_ready), .alu_out(alu_out), .alu_overflow(alu_overflow),
    .alu_underflow(alu_underflow), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .res_overflow(res_overflow),
    .res_underflow(res_underflow), .count(count), .flags_clr(flags_clr),
    .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf)
  );

  typedef struct {
    logic [255:0] d;
    logic [3:0]   t;
    logic         o;
    logic         u;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] popped[$];
  int         tests_run = 0;
  int         tests_failed = 0;
  logic       m_pv = 1'b0;
  logic [3:0] m_pt = '0;
  logic       m_so = 1'b0, m_su = 1'b0;
  logic       g_ovf = 1'b0, g_unf = 1'b0, g_clr = 1'b0, g_rst = 1'b1;
  logic       use_fixed = 1'b0, chk_en = 1'b0, last_acc = 1'b0;
  int         n_acc = 0;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // One clock: drive inputs at negedge, check outputs against the model, step the model.
  task automatic cycle(input logic iv, input logic [3:0] tg, input logic rr);
    logic         exp_rdy;
    logic [255:0] d;
    exp_t         head;
    exp_rdy = (sb.size() + (m_pv ? 1 : 0)) < 4;
    d = use_fixed ? 256'h0102 : rand256();
    issue_valid = iv; issue_tag = tg; res_ready = rr;
    flags_clr = g_clr; rst_n = g_rst;
    alu_out = d; alu_overflow = g_ovf; alu_underflow = g_unf;
    if (chk_en) begin
      tests_run++;
      if (issue_ready !== exp_rdy) begin
        tests_failed++; $display("FAIL issue_ready: got %b expected %b", issue_ready, exp_rdy);
      end
      tests_run++;
      if (res_valid !== (sb.size() != 0)) begin
        tests_failed++; $display("FAIL res_valid: got %b expected %b", res_valid, sb.size() != 0);
      end
      tests_run++;
      if (count !== 3'(sb.size())) begin
        tests_failed++; $display("FAIL count: got %0d expected %0d", count, sb.size());
      end
      if (sb.size() != 0) begin
        head = sb[0];
        tests_run++;
        if (res_data !== head.d || res_tag !== head.t || res_overflow !== head.o ||
            res_underflow !== head.u) begin
          tests_failed++;
          $display("FAIL head: got tag %0h o%b u%b data %h expected tag %0h o%b u%b data %h",
                   res_tag, res_overflow, res_underflow, res_data, head.t, head.o, head.u, head.d);
        end
      end
      tests_run++;
      if (sticky_ovf !== (STICKY & m_so) || sticky_unf !== (STICKY & m_su)) begin
        tests_failed++;
        $display("FAIL sticky: got %b%b expected %b%b", sticky_ovf, sticky_unf,
                 STICKY & m_so, STICKY & m_su);
      end
    end
    @(posedge clk);
    last_acc = 1'b0;
    if (!g_rst) begin
      sb.delete(); m_pv = 1'b0; m_so = 1'b0; m_su = 1'b0;
    end else begin
      if (sb.size() != 0 && rr) begin
        head = sb.pop_front();
        popped.push_back(head.t);
      end
      if (m_pv) sb.push_back('{d, m_pt, g_ovf, g_unf});
      if (g_clr) begin
        m_so = 1'b0; m_su = 1'b0;
      end else begin
        m_so = m_so | (m_pv & g_ovf);
        m_su = m_su | (m_pv & g_unf);
      end
      m_pv = iv && exp_rdy; m_pt = tg;
      if (m_pv) begin
        n_acc++; last_acc = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb.size() != 0 || m_pv) && guard < 20) begin
      cycle(1'b0, 4'h0, 1'b1); guard++;
    end
    tests_run++;
    if (sb.size() != 0 || m_pv) begin
      tests_failed++; $display("FAIL drain_timeout: got %0d left expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    g_rst = 1'b0;
    cycle(1'b0, 4'h0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    g_rst = 1'b1;
    tests_run++;
    if (res_valid !== 1'b0 || count !== 3'd0 || issue_ready !== 1'b1 || res_data !== '0 ||
        res_tag !== '0 || sticky_ovf !== 1'b0 || sticky_unf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got v%b c%0d r%b tag%0h so%b su%b expected v0 c0 r1 tag0 so0 su0",
               res_valid, count, issue_ready, res_tag, sticky_ovf, sticky_unf);
    end
    chk_en = 1'b1;
  endtask

  task automatic test_single();
    use_fixed = 1'b1;
    cycle(1'b1, 4'd3, 1'b1);
    tests_run++;
    if (res_valid !== 1'b0) begin
      tests_failed++; $display("FAIL single_early: got %b expected 0", res_valid);
    end
    cycle(1'b0, 4'h0, 1'b0);
    tests_run++;
    if (res_valid !== 1'b1 || res_tag !== 4'd3 || res_data !== 256'h0102) begin
      tests_failed++;
      $display("FAIL single_result: got v%b tag%0h data %h expected v1 tag3 data 0102",
               res_valid, res_tag, res_data);
    end
    use_fixed = 1'b0;
    cycle(1'b0, 4'h0, 1'b1);
    tests_run++;
    if (count !== 3'd0) begin
      tests_failed++; $display("FAIL single_count: got %0d expected 0", count);
    end
  endtask

  task automatic test_fill();
    n_acc = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'(i + 8), 1'b0);
    cycle(1'b1, 4'hf, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    tests_run++;
    if (n_acc != 4 || count !== 3'd4 || issue_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill: got acc %0d count %0d ready %b expected acc 4 count 4 ready 0",
               n_acc, count, issue_ready);
    end
  endtask

  task automatic test_drain_wrap();
    int i = 0;
    int guard = 0;
    logic [3:0] exp_tags[10];
    logic ok;
    exp_tags = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    popped.delete();
    while (i < 6 && guard < 40) begin
      cycle(1'b1, 4'(i), 1'b1);
      if (last_acc) i++;
      guard++;
    end
    tests_run++;
    if (i != 6) begin
      tests_failed++; $display("FAIL drain_issue_timeout: got %0d issued expected 6", i);
    end
    drain();
    ok = (popped.size() == 10);
    if (ok) for (int k = 0; k < 10; k++) if (popped[k] !== exp_tags[k]) ok = 1'b0;
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL drain_order: got %0d pops %p expected 10 pops %p",
                               popped.size(), popped, exp_tags);
    end
  endtask

  task automatic test_simul();
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 4), 1'b0);
    cycle(1'b0, 4'h0, 1'b1);
    tests_run++;
    if (count !== 3'd3) begin
      tests_failed++; $display("FAIL simul_near_full: got %0d expected 3", count);
    end
    drain();
    cycle(1'b1, 4'd7, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    tests_run++;
    if (count !== 3'd1) begin
      tests_failed++; $display("FAIL simul_empty: got %0d expected 1", count);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    n_acc = 0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i), 1'b1);
    tests_run++;
    if (n_acc != 8 || count !== 3'd1) begin
      tests_failed++; $display("FAIL back_to_back: got acc %0d count %0d expected acc 8 count 1",
                               n_acc, count);
    end
    drain();
  endtask

  task automatic test_sticky();
    cycle(1'b1, 4'd1, 1'b1);
    g_ovf = 1'b1;
    cycle(1'b0, 4'h0, 1'b1);
    g_ovf = 1'b0;
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    tests_run++;
    if (sticky_ovf !== STICKY) begin
      tests_failed++; $display("FAIL sticky_hold: got %b expected %b", sticky_ovf, STICKY);
    end
    cycle(1'b1, 4'd2, 1'b1);
    g_ovf = 1'b1; g_clr = 1'b1;
    cycle(1'b0, 4'h0, 1'b1);
    g_ovf = 1'b0; g_clr = 1'b0;
    tests_run++;
    if (sticky_ovf !== 1'b0) begin
      tests_failed++; $display("FAIL sticky_clr_priority: got %b expected 0", sticky_ovf);
    end
    cycle(1'b1, 4'd3, 1'b1);
    g_unf = 1'b1;
    cycle(1'b0, 4'h0, 1'b1);
    g_unf = 1'b0;
    tests_run++;
    if (sticky_unf !== STICKY) begin
      tests_failed++; $display("FAIL sticky_unf: got %b expected %b", sticky_unf, STICKY);
    end
    g_clr = 1'b1;
    cycle(1'b0, 4'h0, 1'b1);
    g_clr = 1'b0;
    drain();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 12), 1'b0);
    tests_run++;
    if (count !== 3'd3) begin
      tests_failed++; $display("FAIL mid_setup: got %0d expected 3", count);
    end
    g_rst = 1'b0;
    cycle(1'b0, 4'h0, 1'b0);
    g_rst = 1'b1;
    tests_run++;
    if (res_valid !== 1'b0 || count !== 3'd0 || issue_ready !== 1'b1) begin
      tests_failed++; $display("FAIL mid_reset: got v%b c%0d r%b expected v0 c0 r1",
                               res_valid, count, issue_ready);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_tag = '0; res_ready = 1'b0;
    alu_out = '0; alu_overflow = 1'b0; alu_underflow = 1'b0; flags_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_drain_wrap();
    test_simul();
    test_back_to_back();
    test_sticky();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
